// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes, one product in flight.
// Optional build macro SHIFT_ADD_EARLY_TERMINATE_EN: finish as soon as no multiplier bits remain.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   b_next;
    logic [CW-1:0]      count;
    logic               last;

    always_comb begin
        acc_next = b_sh[0] ? (acc + a_sh) : acc;
        b_next   = b_sh >> 1;
`ifdef SHIFT_ADD_EARLY_TERMINATE_EN
        last     = (count == CW'(WIDTH - 1)) || (b_next == '0);
`else
        last     = (count == CW'(WIDTH - 1));
`endif
    end

    // Handshake outputs are registered copies of the next state, so in_ready
    // stays low while reset is held and rises on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            count     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_sh     <= {{WIDTH{1'b0}}, a};
                        b_sh     <= b;
                        acc      <= '0;
                        count    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    a_sh  <= a_sh << 1;
                    b_sh  <= b_next;
                    count <= count + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        product   <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed vectors at WIDTH=8 plus one WIDTH=256 corner.
module tb_shift_add_multiplier;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] product;

    logic           iv256, ir256, ov256, or256, busy256;
    logic [255:0]   a256, b256;
    logic [511:0]   p256;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    shift_add_multiplier #(.WIDTH(256)) dut256 (
        .clk(clk), .reset(reset), .in_valid(iv256), .in_ready(ir256),
        .a(a256), .b(b256), .out_valid(ov256), .out_ready(or256),
        .product(p256), .busy(busy256)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2*W-1:0] p;
        int             due;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] bv);
        int l;
`ifdef SHIFT_ADD_EARLY_TERMINATE_EN
        l = 1;
        for (int i = 0; i < W; i++) if (bv[i]) l = i + 1;
`else
        l = W;
`endif
        return l;
    endfunction

    // Monitor: pops one expectation per rising out_valid and checks hold stability.
    logic           prev_ov = 1'b0;
    logic [2*W-1:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (busy) check("in_ready_while_busy", {511'd0, in_ready}, 512'd0);
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 512'd1, 512'd0);
                end else begin
                    e = q.pop_front();
                    check("product", product, e.p);
                    check("latency_cycle", cyc, e.due);
                end
                held = product;
            end else if (out_valid) begin
                check("product_hold", product, held);
            end
            prev_ov = out_valid;
        end
    end

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("ready_timeout", 512'd0, 512'd1);
            return;
        end
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        q.push_back('{p: (2*W)'(av) * (2*W)'(bv), due: cyc + exp_lat(bv)});
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(q.size() == 0 && in_ready && !busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", {511'd0, (q.size() == 0 && in_ready && !busy)}, 512'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] e256;
        int t;
        int due256;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        iv256 = 1'b0; or256 = 1'b1; a256 = '0; b256 = '0;
        repeat (2) @(negedge clk);
        check("rst_product", product, 512'd0);
        check("rst_out_valid", {511'd0, out_valid}, 512'd0);
        check("rst_busy", {511'd0, busy}, 512'd0);
        check("rst_in_ready", {511'd0, in_ready}, 512'd0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {511'd0, in_ready}, 512'd1);

        // Full-scale operands
        issue(8'd255, 8'd255);
        wait_idle();

        // Backpressure: hold for 5 cycles, then a single out_ready pulse
        out_ready = 1'b0;
        issue(8'd13, 8'd11);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_seen", {511'd0, out_valid}, 512'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", {511'd0, out_valid}, 512'd1);
            check("bp_product_held", product, 512'd143);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_in_ready_next", {511'd0, in_ready}, 512'd1);
        check("bp_out_valid_drop", {511'd0, out_valid}, 512'd0);
        check("bp_product_kept", product, 512'd143);
        out_ready = 1'b1;

        // Operands offered during RUN must be ignored
        issue(8'd3, 8'd5);
        @(negedge clk);
        in_valid = 1'b1; a = 8'd7; b = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);
        check("ignored_product", product, 512'd15);

        // Reset mid-RUN aborts with no output
        issue(8'd200, 8'd100);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        q.delete();
        check("abort_out_valid", {511'd0, out_valid}, 512'd0);
        check("abort_busy", {511'd0, busy}, 512'd0);
        check("abort_in_ready", {511'd0, in_ready}, 512'd0);
        @(negedge clk);
        check("abort_in_ready_held", {511'd0, in_ready}, 512'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready_after", {511'd0, in_ready}, 512'd1);
        issue(8'd2, 8'd3);
        wait_idle();

        // Edge operands and early-termination patterns
        issue(8'd0, 8'hAB);
        issue(8'hFF, 8'd1);
        issue(8'd100, 8'd3);
        issue(8'd7, 8'd0);
        issue(8'd5, 8'h80);
        wait_idle();

        // WIDTH=256 all-ones corner: (2^256-1)^2 = 2^512 - 2^257 + 1
        e256 = 512'd0 - (512'd1 << 257) + 512'd1;
        @(negedge clk);
        check("w256_in_ready", {511'd0, ir256}, 512'd1);
        iv256 = 1'b1; a256 = '1; b256 = '1;
        @(posedge clk);
        #1;
        due256 = cyc + 256;
        iv256 = 1'b0; a256 = '0; b256 = '0;
        t = 0;
        @(negedge clk);
        while (!ov256 && t < 600) begin
            @(negedge clk);
            t++;
        end
        check("w256_latency_cycle", cyc, due256);
        check("w256_product", p256, e256);

        wait_idle();
        check("queue_drained", q.size(), 512'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
